// File: rtl/adder_error_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   mon_state_t : run-control states of the monitor FSM
//   *_DEF       : default adder width, fraction bits and sample-counter width
//   ed_sum_w    : width of the absolute-error accumulator (never overflows)
//   red_sum_w   : width of the relative-error accumulator (never overflows)
//   div_cycles  : cycles spent per relative-error division (one quotient bit each)
package adder_error_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DIVIDE,
    ST_DONE
  } mon_state_t;

  localparam int N_DEF     = 16;
  localparam int FRAC_DEF  = 16;
  localparam int CNT_W_DEF = 32;

  function automatic int ed_sum_w(input int n, input int cnt_w);
    return n + cnt_w;
  endfunction

  function automatic int red_sum_w(input int n, input int frac, input int cnt_w);
    return n + frac + cnt_w;
  endfunction

  function automatic int div_cycles(input int n, input int frac);
    return n + frac;
  endfunction

  localparam int ED_SUM_W_DEF   = ed_sum_w(N_DEF, CNT_W_DEF);
  localparam int RED_SUM_W_DEF  = red_sum_w(N_DEF, FRAC_DEF, CNT_W_DEF);
  localparam int DIV_CYCLES_DEF = div_cycles(N_DEF, FRAC_DEF);

endpackage

// File: rtl/error_ratio_divider.sv
// Sequential restoring divider producing floor(dividend / divisor).
// One quotient bit per cycle; a run takes div_cycles(N, FRAC) cycles after
// the start edge. quotient is valid only in the cycle where done is high
// (it already contains the final bit computed in that cycle).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin a division (ignored while running)
//   dividend   : N+FRAC-bit numerator (ED scaled by 2^FRAC)
//   divisor    : N-bit nonzero denominator
//   quotient   : N+FRAC-bit result, qualified by done
//   done       : one-cycle pulse on the final division step
module error_ratio_divider
  import adder_error_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N+FRAC-1:0]     dividend,
  input  logic [N-1:0]          divisor,
  output logic [N+FRAC-1:0]     quotient,
  output logic                  done
);

  localparam int DW = div_cycles(N, FRAC);
  localparam int CW = $clog2(DW + 1);

  logic          active;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  rem;
  logic [N-1:0]  dsr;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DW-1:0] dq;

  logic [N:0]    rem_sh;
  logic [N:0]    rem_sub;
  logic          q_bit;
  logic [N-1:0]  rem_nxt;

  always_comb begin
    rem_sh   = {rem, dq[DW-1]};
    rem_sub  = rem_sh - {1'b0, dsr};
    q_bit    = (rem_sh >= {1'b0, dsr});
    // Remainder stays below the divisor, so it always fits in N bits.
    rem_nxt  = q_bit ? rem_sub[N-1:0] : rem_sh[N-1:0];
    quotient = {dq[DW-2:0], q_bit};
    done     = active && (bit_cnt == CW'(DW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= '0;
    end else if (start && !active) begin
      active  <= 1'b1;
      bit_cnt <= '0;
    end else if (active) begin
      active  <= !done;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start && !active) begin
      rem <= '0;
      dsr <= divisor;
      dq  <= dividend;
    end else if (active) begin
      rem <= rem_nxt;
      dq  <= quotient;
    end
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Error-characterization engine for approximate adders. Consumes
// (approx, exact) sum pairs for a programmed number of samples and
// accumulates the raw terms for ER, MED, max error and MRED.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a run (only honoured in IDLE); clears all results
//   num_samples  : pairs per run, captured on an accepted start
//   in_valid     : pair available; in_ready : monitor accepting (ACCEPT only)
//   approx_sum   : approximate adder output; exact_sum : exact sum mod 2^N
//   busy         : run in progress (ACCEPT or DIVIDE); done : end-of-run pulse
//   sample_count : pairs consumed;         err_count   : pairs with approx!=exact
//   ed_sum       : sum of |approx-exact|;  ed_max      : max |approx-exact|
//   valid_count  : pairs with exact!=0;    red_sum     : sum of floor(ED*2^FRAC/exact)
module adder_error_monitor
  import adder_error_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    num_samples,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0]                        approx_sum,
  input  logic [N-1:0]                        exact_sum,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_W-1:0]                    sample_count,
  output logic [CNT_W-1:0]                    err_count,
  output logic [ed_sum_w(N, CNT_W)-1:0]       ed_sum,
  output logic [N-1:0]                        ed_max,
  output logic [CNT_W-1:0]                    valid_count,
  output logic [red_sum_w(N, FRAC, CNT_W)-1:0] red_sum
);

  localparam int QW = div_cycles(N, FRAC);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [CNT_W-1:0] num_q;

  logic             xfer;
  logic [N-1:0]     ed;
  logic             launch;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_xfer;
  logic [QW-1:0]    div_quot;
  logic             div_done;

  always_comb begin
    xfer      = (state == ST_ACCEPT) && in_valid;
    ed        = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                          : (exact_sum - approx_sum);
    launch    = xfer && (exact_sum != '0) && (ed != '0);
    cnt_inc   = sample_count + 1'b1;
    last_xfer = (cnt_inc == num_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_samples == '0) ? ST_DONE : ST_ACCEPT;
      ST_ACCEPT: if (xfer) begin
                   if (launch)         state_nxt = ST_DIVIDE;
                   else if (last_xfer) state_nxt = ST_DONE;
                 end
      // sample_count already includes the pair being divided.
      ST_DIVIDE: if (div_done) state_nxt = (sample_count == num_q) ? ST_DONE : ST_ACCEPT;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control: state and registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      num_q    <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == ST_ACCEPT);
      busy     <= (state_nxt == ST_ACCEPT) || (state_nxt == ST_DIVIDE);
      done     <= (state_nxt == ST_DONE);
      if (state == ST_IDLE && start) num_q <= num_samples;
    end
  end

  // Results: cleared on accepted start, updated per transfer / finished divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
      valid_count  <= '0;
      red_sum      <= '0;
    end else if (state == ST_IDLE && start) begin
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
      valid_count  <= '0;
      red_sum      <= '0;
    end else begin
      if (xfer) begin
        sample_count <= cnt_inc;
        if (ed != '0)        err_count   <= err_count + 1'b1;
        ed_sum <= ed_sum + {{CNT_W{1'b0}}, ed};
        if (ed > ed_max)     ed_max      <= ed;
        if (exact_sum != '0) valid_count <= valid_count + 1'b1;
      end
      if (state == ST_DIVIDE && div_done)
        red_sum <= red_sum + {{CNT_W{1'b0}}, div_quot};
    end
  end

  error_ratio_divider #(
    .N    (N),
    .FRAC (FRAC)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (launch),
    .dividend ({ed, {FRAC{1'b0}}}),
    .divisor  (exact_sum),
    .quotient (div_quot),
    .done     (div_done)
  );

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed self-checking bench for adder_error_monitor at default widths.
module tb_adder_error_monitor;

  localparam int N     = 16;
  localparam int FRAC  = 16;
  localparam int CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_samples = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N-1:0]       approx_sum = '0;
  logic [N-1:0]       exact_sum = '0;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_count;
  logic [CNT_W-1:0]   err_count;
  logic [N+CNT_W-1:0] ed_sum;
  logic [N-1:0]       ed_max;
  logic [CNT_W-1:0]   valid_count;
  logic [N+FRAC+CNT_W-1:0] red_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_error_monitor #(.N(N), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .approx_sum   (approx_sum),
    .exact_sum    (exact_sum),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .ed_sum       (ed_sum),
    .ed_max       (ed_max),
    .valid_count  (valid_count),
    .red_sum      (red_sum)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [CNT_W-1:0] n);
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] e);
    approx_sum = a;
    exact_sum  = e;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  // Cycles from a dividing transfer until in_ready or done rises (bounded).
  task automatic wait_div(output int k);
    k = 0;
    while (!in_ready && !done && k < 100) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int dn;

    // Reset state
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_done",  64'(done),     64'd0);
    chk("rst_cnt",   64'(sample_count), 64'd0);
    chk("rst_red",   64'(red_sum),  64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Three non-dividing pairs back to back
    begin_run(32'd3);
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_busy",  64'(busy),     64'd1);
    approx_sum = 16'd100; exact_sum = 16'd100; in_valid = 1'b1;
    tick();
    chk("t1_cnt1",  64'(sample_count), 64'd1);
    chk("t1_done1", 64'(done), 64'd0);
    approx_sum = 16'd0; exact_sum = 16'd0;
    tick();
    chk("t1_cnt2",  64'(sample_count), 64'd2);
    chk("t1_done2", 64'(done), 64'd0);
    approx_sum = 16'd5; exact_sum = 16'd5;
    tick();
    in_valid = 1'b0;
    chk("t1_done",  64'(done), 64'd1);
    chk("t1_cnt",   64'(sample_count), 64'd3);
    chk("t1_err",   64'(err_count), 64'd0);
    chk("t1_edsum", 64'(ed_sum), 64'd0);
    chk("t1_edmax", 64'(ed_max), 64'd0);
    chk("t1_valid", 64'(valid_count), 64'd2);
    chk("t1_red",   64'(red_sum), 64'd0);
    chk("t1_rdy0",  64'(in_ready), 64'd0);
    tick();
    chk("t1_done_after", 64'(done), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // One dividing pair: 10*65536/100
    begin_run(32'd1);
    send(16'd90, 16'd100);
    chk("t2_rdy_low", 64'(in_ready), 64'd0);
    chk("t2_busy",    64'(busy), 64'd1);
    wait_div(k);
    chk("t2_latency", 64'(k), 64'd32);
    chk("t2_done",    64'(done), 64'd1);
    chk("t2_red",     64'(red_sum), 64'd6553);
    chk("t2_edsum",   64'(ed_sum), 64'd10);
    chk("t2_edmax",   64'(ed_max), 64'd10);
    chk("t2_err",     64'(err_count), 64'd1);
    chk("t2_valid",   64'(valid_count), 64'd1);
    chk("t2_cnt",     64'(sample_count), 64'd1);
    tick();
    chk("t2_done_after", 64'(done), 64'd0);

    // Largest error with divisor 1, then an exact-zero pair
    begin_run(32'd2);
    send(16'hFFFF, 16'h0001);
    wait_div(k);
    chk("t3_rdy_low_cycles", 64'(k), 64'd32);
    chk("t3_ready", 64'(in_ready), 64'd1);
    chk("t3_red_mid", 64'(red_sum), 64'd4294836224);
    chk("t3_done_mid", 64'(done), 64'd0);
    send(16'h0000, 16'h0000);
    chk("t3_done",  64'(done), 64'd1);
    chk("t3_edmax", 64'(ed_max), 64'd65534);
    chk("t3_edsum", 64'(ed_sum), 64'd65534);
    chk("t3_valid", 64'(valid_count), 64'd1);
    chk("t3_cnt",   64'(sample_count), 64'd2);
    chk("t3_err",   64'(err_count), 64'd1);
    chk("t3_red",   64'(red_sum), 64'd4294836224);
    tick();

    // Zero-sample run
    begin_run(32'd0);
    chk("t4_done",  64'(done), 64'd1);
    chk("t4_ready", 64'(in_ready), 64'd0);
    chk("t4_cnt",   64'(sample_count), 64'd0);
    chk("t4_red",   64'(red_sum), 64'd0);
    chk("t4_edsum", 64'(ed_sum), 64'd0);
    chk("t4_edmax", 64'(ed_max), 64'd0);
    tick();
    chk("t4_done_after",  64'(done), 64'd0);
    chk("t4_ready_after", 64'(in_ready), 64'd0);

    // Reset during divide cycle 10
    begin_run(32'd1);
    send(16'd90, 16'd100);
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd0);
    chk("t5_cnt",   64'(sample_count), 64'd0);
    chk("t5_edsum", 64'(ed_sum), 64'd0);
    chk("t5_err",   64'(err_count), 64'd0);
    chk("t5_valid", 64'(valid_count), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    chk("t5_no_done", 64'(dn), 64'd0);
    begin_run(32'd1);
    send(16'd90, 16'd100);
    wait_div(k);
    chk("t5_rerun_done", 64'(done), 64'd1);
    chk("t5_rerun_red",  64'(red_sum), 64'd6553);
    tick();

    // in_valid in IDLE and start during ACCEPT are ignored
    approx_sum = 16'd7; exact_sum = 16'd3; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("t6_idle_cnt",   64'(sample_count), 64'd1);
    chk("t6_idle_edsum", 64'(ed_sum), 64'd10);
    chk("t6_idle_ready", 64'(in_ready), 64'd0);
    begin_run(32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_cnt",   64'(sample_count), 64'd0);
    chk("t6_start_ready", 64'(in_ready), 64'd1);
    send(16'd0, 16'd0);
    chk("t6_cnt1", 64'(sample_count), 64'd1);
    num_samples = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_ready2", 64'(in_ready), 64'd1);
    chk("t6_done2",  64'(done), 64'd0);
    chk("t6_cnt2",   64'(sample_count), 64'd1);
    send(16'd4, 16'd4);
    chk("t6_done",  64'(done), 64'd1);
    chk("t6_cnt",   64'(sample_count), 64'd2);
    chk("t6_valid", 64'(valid_count), 64'd1);
    chk("t6_err",   64'(err_count), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
# adder_error_monitor

Synthesizable on-chip error-characterization engine for the approximate-adder family. It sits downstream of an approximate adder and its exact reference. It consumes (approximate sum, exact sum) pairs over a valid/ready handshake for a programmed number of samples, and accumulates the raw terms for error rate, MED, max error and MRED. Host software derives ER = err_count/sample_count, MED = ed_sum/sample_count, NMED = MED/ed_max and MRED = red_sum/(valid_count·2^FRAC).

## Interface
- N, 16, adder/sum width
- FRAC, 16, fractional bits of relative-error quotient
- CNT_W, 32, sample counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin run; clears accumulators; ignored unless IDLE
- num_samples  in  CNT_W  samples per run, sampled on accepted start
- in_valid  in  1  pair available
- in_ready  out  1  monitor can accept a pair
- approx_sum  in  N  approximate adder output
- exact_sum  in  N  exact sum, mod 2^N
- busy  out  1  state ∈ {ACCEPT, DIVIDE}
- done  out  1  one-cycle pulse at run end
- sample_count  out  CNT_W  pairs consumed
- err_count  out  CNT_W  pairs with approx≠exact
- ed_sum  out  N+CNT_W  Σ|approx−exact|
- ed_max  out  N  max |approx−exact|
- valid_count  out  CNT_W  pairs with exact≠0
- red_sum  out  N+FRAC+CNT_W  Σ floor(ED·2^FRAC/exact) over exact≠0

## Operation
- FSM states: IDLE, ACCEPT, DIVIDE, DONE.
- IDLE → ACCEPT on start when num_samples≠0. IDLE → DONE on start when num_samples=0. In both cases all accumulators and counters clear.
- ACCEPT: in_ready=1. A transfer occurs on in_valid∧in_ready. On each transfer:
  - ED=|approx−exact| as N-bit unsigned.
  - sample_count++; err_count++ if ED≠0; ed_sum+=ED; ed_max=max(ed_max,ED).
  - If exact≠0: valid_count++.
  - If exact≠0 and ED≠0: launch divider, go to DIVIDE.
  - Else, if sample_count (new) = num_samples: go to DONE. Otherwise stay in ACCEPT.
- DIVIDE: restoring division of ED·2^FRAC by exact, one quotient bit per cycle, N+FRAC cycles. On the final cycle red_sum += quotient (N+FRAC bits). Then go to DONE if the count is reached, else to ACCEPT.
- DONE: done=1 for one cycle, then IDLE. Results hold until the next accepted start.
- Accumulator widths are chosen so none can overflow within 2^CNT_W−1 samples. No saturation or wrap logic.
- exact=0 pairs contribute to ER/MED/max only and are excluded from valid_count and red_sum.
- start while busy or in DONE: ignored. in_valid outside ACCEPT: not consumed.

## Timing
- Reset (async assert, sync release): state IDLE. in_ready, busy and done are 0. All result outputs are 0.
- in_ready is a registered state decode: high exactly when state=ACCEPT.
- Non-dividing pairs: throughput of one per cycle. Results are visible the cycle after the transfer.
- Dividing pair: in_ready is low for exactly N+FRAC cycles after the transfer edge (32 at defaults). red_sum updates on the last DIVIDE edge.
- done goes high the cycle after the final transfer (non-dividing) or the cycle after the final DIVIDE cycle. When num_samples=0, done goes high the cycle after start.
- Reset mid-run, including mid-divide: immediate return to the reset state. The partial run is discarded and no done pulse is produced.

## Structure
- Package adder_error_pkg holds:
  - the state enum;
  - localparams for accumulator widths (N+CNT_W, N+FRAC+CNT_W);
  - the divide-cycle count N+FRAC.
- Sub-module error_ratio_divider: sequential restoring divider.
  - Inputs: start, dividend ED·2^FRAC, divisor exact.
  - Outputs: quotient, done pulse.
  - Owns its own bit counter.
- The top level holds the FSM, ED datapath, counters and accumulators.

## Test plan
- num_samples=3, pairs (100,100), (0,0), (5,5), in_valid held high → three consecutive transfers; err_count=0, ed_sum=0, ed_max=0, valid_count=2, red_sum=0; done pulses exactly once, the cycle after the third transfer.
- num_samples=1, approx=90, exact=100 → in_ready low 32 cycles; red_sum=6553, ed_sum=10, ed_max=10, err_count=1, valid_count=1; done on the cycle after the last DIVIDE cycle.
- num_samples=2, pairs (0xFFFF,0x0001) then (0x0000,0x0000) → first quotient 65534·65536=4294836224; ed_max=65534, ed_sum=65534, valid_count=1, sample_count=2.
- start with num_samples=0 → done the next cycle, all results 0, in_ready never high.
- Assert rst_n=0 during DIVIDE cycle 10 → all outputs 0 immediately, no done pulse; a following run of 1 sample (90,100) gives red_sum=6553.
- Pulse start during ACCEPT, and drive in_valid while in IDLE → neither has any effect; counts remain unchanged.
